// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back stage plus the 32-entry architectural register file.
//   clk, rst_n       : pipeline clock, async active-low reset
//   regwrite         : MEM/WB write enable
//   memtoreg         : write-back select (1 = read_data, 0 = mem_alu_result)
//   read_data        : load value from MEM/WB
//   mem_alu_result   : ALU result from MEM/WB
//   mem_write_reg    : destination register from MEM/WB
//   rs_addr, rt_addr : ID-stage read addresses
//   rs_data, rt_data : read data, with optional same-cycle write-through
//   wb_data, wb_we   : selected write-back value and qualified enable, for forwarding
//   wb_count         : committed writes since reset (wraps)
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regwrite,
  input  logic              memtoreg,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [ADDR_W-1:0] mem_write_reg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [31:0]       wb_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [31:0]       cnt_q;
  logic [31:0]       cnt_d;

  // Write-back select and qualified enable; $0 is never a legal target.
  always_comb begin
    wb_data = memtoreg ? read_data : mem_alu_result;
    wb_we   = regwrite && (mem_write_reg != '0);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wb_we) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wb_we) begin
      regs_q[mem_write_reg] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Read ports: $0 is hard zero even if a bypass would match; bypass returns
  // the value committing at the coming edge so ID sees it in the same cycle.
  always_comb begin
    rs_data = regs_q[rs_addr];
    if (BYPASS && wb_we && (rs_addr == mem_write_reg)) rs_data = wb_data;
    if (rs_addr == '0) rs_data = '0;

    rt_data = regs_q[rt_addr];
    if (BYPASS && wb_we && (rt_addr == mem_write_reg)) rt_data = wb_data;
    if (rt_addr == '0) rt_data = '0;
  end

  assign wb_count = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regwrite;
  logic        memtoreg;
  logic [31:0] read_data;
  logic [31:0] mem_alu_result;
  logic [4:0]  mem_write_reg;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data, rt_data, wb_data, wb_count;
  logic        wb_we;
  logic [31:0] nb_rs_data, nb_rt_data, nb_wb_data, nb_wb_count;
  logic        nb_wb_we;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .regwrite(regwrite), .memtoreg(memtoreg),
    .read_data(read_data), .mem_alu_result(mem_alu_result),
    .mem_write_reg(mem_write_reg), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data), .wb_we(wb_we),
    .wb_count(wb_count)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .regwrite(regwrite), .memtoreg(memtoreg),
    .read_data(read_data), .mem_alu_result(mem_alu_result),
    .mem_write_reg(mem_write_reg), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(nb_rs_data), .rt_data(nb_rt_data), .wb_data(nb_wb_data),
    .wb_we(nb_wb_we), .wb_count(nb_wb_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one write at the falling edge, commit at the rising edge, then
  // drop regwrite so later reads see the array rather than the bypass.
  task automatic do_write(input logic [4:0] a, input logic [31:0] v);
    @(negedge clk);
    regwrite = 1'b1; memtoreg = 1'b0; mem_alu_result = v; read_data = ~v;
    mem_write_reg = a;
    @(posedge clk); #1;
    regwrite = 1'b0;
  endtask

  task automatic bubble();
    @(negedge clk);
    regwrite = 1'b0; mem_write_reg = 5'd7; mem_alu_result = 32'hBAD0BAD0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; regwrite = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; regwrite = 1'b0; memtoreg = 1'b0; read_data = '0;
    mem_alu_result = '0; mem_write_reg = '0; rs_addr = '0; rt_addr = '0;
    #3;
    check("reset_count", wb_count, 32'h0);
    check("reset_we", {31'b0, wb_we}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Async reset clears array and counter without a clock edge.
    do_write(5'd5, 32'hDEADBEEF);
    rs_addr = 5'd5; #1;
    check("pre_reset_r5", rs_data, 32'hDEADBEEF);
    check("pre_reset_count", wb_count, 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    check("async_reset_r5", rs_data, 32'h0);
    check("async_reset_count", wb_count, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Write-back mux, both selects.
    @(negedge clk);
    regwrite = 1'b1; mem_write_reg = 5'd8; memtoreg = 1'b0;
    mem_alu_result = 32'h11; read_data = 32'h22; rs_addr = 5'd8; rt_addr = 5'd8;
    #1;
    check("mux_alu_wbdata", wb_data, 32'h11);
    check("mux_wbwe", {31'b0, wb_we}, 32'h1);
    @(posedge clk); #1; regwrite = 1'b0; #1;
    check("mux_alu_r8", rs_data, 32'h11);
    @(negedge clk);
    regwrite = 1'b1; memtoreg = 1'b1; #1;
    check("mux_mem_wbdata", wb_data, 32'h22);
    @(posedge clk); #1; regwrite = 1'b0; #1;
    check("mux_mem_r8", rt_data, 32'h22);
    check("mux_count", wb_count, 32'd2);

    // $0 is never written and always reads zero, even under bypass.
    @(negedge clk);
    regwrite = 1'b1; memtoreg = 1'b0; mem_write_reg = 5'd0;
    mem_alu_result = 32'hFFFFFFFF; rs_addr = 5'd0; rt_addr = 5'd0; #1;
    check("r0_wbwe", {31'b0, wb_we}, 32'h0);
    check("r0_wbdata", wb_data, 32'hFFFFFFFF);
    check("r0_rs_pre", rs_data, 32'h0);
    check("r0_rt_pre", rt_data, 32'h0);
    @(posedge clk); #1;
    check("r0_rs_post", rs_data, 32'h0);
    check("r0_rt_post", rt_data, 32'h0);
    check("r0_count", wb_count, 32'd2);
    regwrite = 1'b0;

    // Same-cycle bypass versus the non-bypassed instance.
    do_write(5'd9, 32'h1);
    @(negedge clk);
    regwrite = 1'b1; memtoreg = 1'b0; mem_write_reg = 5'd9;
    mem_alu_result = 32'hABCD0000; rs_addr = 5'd9; rt_addr = 5'd9; #1;
    check("byp_rs", rs_data, 32'hABCD0000);
    check("byp_rt", rt_data, 32'hABCD0000);
    check("nobyp_rs_pre", nb_rs_data, 32'h1);
    check("nobyp_rt_pre", nb_rt_data, 32'h1);
    @(posedge clk); #1; regwrite = 1'b0; #1;
    check("nobyp_rs_post", nb_rs_data, 32'hABCD0000);
    check("byp_rt_post", rt_data, 32'hABCD0000);
    check("byp_count", wb_count, 32'd4);

    // Reset held across an edge discards the pending write.
    @(negedge clk);
    regwrite = 1'b1; mem_write_reg = 5'd6; mem_alu_result = 32'h66666666;
    #2; rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); regwrite = 1'b0; rst_n = 1'b1;
    rs_addr = 5'd6; #1;
    check("rst_discard_r6", rs_data, 32'h0);
    check("rst_discard_count", wb_count, 32'h0);

    // Writes interleaved with bubbles, then a write to $0.
    do_write(5'd1, 32'h101);
    bubble();
    do_write(5'd2, 32'h102);
    do_write(5'd3, 32'h103);
    bubble();
    do_write(5'd4, 32'h104);
    bubble();
    do_write(5'd5, 32'h105);
    do_write(5'd0, 32'h100);
    check("bubble_count", wb_count, 32'd5);
    rs_addr = 5'd1; rt_addr = 5'd2; #1;
    check("bubble_r1", rs_data, 32'h101);
    check("bubble_r2", rt_data, 32'h102);
    rs_addr = 5'd3; rt_addr = 5'd4; #1;
    check("bubble_r3", rs_data, 32'h103);
    check("bubble_r4", rt_data, 32'h104);
    rs_addr = 5'd5; rt_addr = 5'd7; #1;
    check("bubble_r5", rs_data, 32'h105);
    check("bubble_r7", rt_data, 32'h0);

    // Counter wrap.
    @(negedge clk);
    force dut.cnt_q = 32'hFFFFFFFF; #1;
    release dut.cnt_q; #1;
    check("wrap_pre", wb_count, 32'hFFFFFFFF);
    do_write(5'd3, 32'h33333333);
    rs_addr = 5'd3; #1;
    check("wrap_count", wb_count, 32'h0);
    check("wrap_r3", rs_data, 32'h33333333);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
